// File: rtl/mcycle_unit_if.sv
// Request/result bundle between the Execute stage and the multi-cycle mul/div unit.
// The pipeline drives the request side; the unit drives results, WA3R and the Busy/Done handshake.
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [3:0]       WA3E;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic [3:0]       WA3R;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2, WA3E,
        input  Result1, Result2, WA3R, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2, WA3E,
        output Result1, Result2, WA3R, Busy, Done
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider; MCYCLE_EARLY_TERM_EN shortens multiplies.
// Latency: Start at edge T -> Busy T+1..T+WIDTH, Done pulse at T+WIDTH+1 (fewer iterations for early-term muls).
// Backpressure: Start is taken only in IDLE or DONE; Start during COMPUTE is ignored.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RESETn,
    mcycle_unit_if.slave bus
);
    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_FULL = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, last_q, last_d;
    logic                 is_div_q, neg_q, rneg_q, div0_q;
    logic [WIDTH-1:0]     op1_q, opb_q, res1_q, res2_q;
    logic [WIDTH-1:0]     opb_step, res1_d, res2_d, a_mag, b_mag, rem_sub;
    logic [2*WIDTH-1:0]   acc_q, mcand_q, acc_step, mcand_step, prod;
    logic [WIDTH:0]       rem_sh;
    logic [3:0]           wa3r_q;
    logic                 accept, finish, is_signed, a_neg, b_neg;

    assign is_signed = ~bus.MCycleOp[0];
    assign a_neg     = is_signed & bus.Operand1[WIDTH-1];
    assign b_neg     = is_signed & bus.Operand2[WIDTH-1];
    assign a_mag     = a_neg ? -bus.Operand1 : bus.Operand1;
    assign b_mag     = b_neg ? -bus.Operand2 : bus.Operand2;
    assign accept    = bus.Start && (state_q != COMPUTE);
    assign finish    = (state_q == COMPUTE) && (cnt_q == last_q);

`ifdef MCYCLE_EARLY_TERM_EN
    function automatic logic [CW-1:0] msb_idx(input logic [WIDTH-1:0] v);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    // Multiplies stop once every set multiplier bit has been consumed.
    assign last_d = bus.MCycleOp[1] ? LAST_FULL : msb_idx(b_mag);
`else
    assign last_d = LAST_FULL;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.Start) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
            end
            COMPUTE: begin
                if (cnt_q == last_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One iteration: multiplier consumes its LSB, divider produces one quotient bit MSB-first.
    always_comb begin
        acc_step   = acc_q;
        mcand_step = mcand_q;
        opb_step   = opb_q;
        rem_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_sub    = rem_sh[WIDTH-1:0] - opb_q;
        if (!is_div_q) begin
            acc_step   = acc_q + (opb_q[0] ? mcand_q : '0);
            mcand_step = mcand_q << 1;
            opb_step   = opb_q >> 1;
        end else if (rem_sh >= {1'b0, opb_q}) begin
            acc_step = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        if (!is_div_q) begin
            res1_d = prod[WIDTH-1:0];
            res2_d = prod[2*WIDTH-1:WIDTH];
        end else if (div0_q) begin
            res1_d = '1;
            res2_d = op1_q;
        end else begin
            res1_d = neg_q  ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
            res2_d = rneg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            op1_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            last_q   <= '0;
            wa3r_q   <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
        end else begin
            if (accept) begin
                is_div_q <= bus.MCycleOp[1];
                neg_q    <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
                div0_q   <= (bus.Operand2 == '0);
                op1_q    <= bus.Operand1;
                opb_q    <= b_mag;
                last_q   <= last_d;
                wa3r_q   <= bus.WA3E;
                if (bus.MCycleOp[1]) begin
                    acc_q   <= {{WIDTH{1'b0}}, a_mag};
                    mcand_q <= '0;
                end else begin
                    acc_q   <= '0;
                    mcand_q <= {{WIDTH{1'b0}}, a_mag};
                end
            end else if (state_q == COMPUTE) begin
                acc_q   <= acc_step;
                mcand_q <= mcand_step;
                opb_q   <= opb_step;
            end
            if (finish) begin
                res1_q <= res1_d;
                res2_q <= res2_d;
            end
        end
    end

    assign bus.Busy    = (state_q == COMPUTE);
    assign bus.Done    = (state_q == DONE);
    assign bus.Result1 = res1_q;
    assign bus.Result2 = res2_q;
    assign bus.WA3R    = wa3r_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed testbench for mcycle_unit (WIDTH=32); honours MCYCLE_EARLY_TERM_EN for the early-term scenario.
module tb_mcycle_unit;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mcycle_unit_if #(.WIDTH(W)) bus ();

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] wa);
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        bus.WA3E     = wa;
        bus.Start    = 1'b1;
        tick();
        bus.Start    = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after the Start edge) at which Done is seen.
    task automatic wait_done(output int idx, output int nbusy);
        idx   = 1;
        nbusy = 0;
        while (bus.Done !== 1'b1 && idx < 200) begin
            if (bus.Busy === 1'b1) nbusy++;
            tick();
            idx++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Start = 1'b0; bus.MCycleOp = 2'b00; bus.Operand1 = '0; bus.Operand2 = '0; bus.WA3E = '0;
        tick(); tick();
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        total++; if (bus.Result1 !== 32'h0) begin bad++; $display("FAIL reset_r1: got %h want 0", bus.Result1); end
        total++; if (bus.Result2 !== 32'h0) begin bad++; $display("FAIL reset_r2: got %h want 0", bus.Result2); end
        total++; if (bus.WA3R !== 4'h0) begin bad++; $display("FAIL reset_wa3r: got %h want 0", bus.WA3R); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_umul();
        int idx, nb;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
        total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL umul_busy_first: got %b want 1", bus.Busy); end
        wait_done(idx, nb);
        total++; if (idx != 33) begin bad++; $display("FAIL umul_done_cycle: got %0d want 33", idx); end
        total++; if (nb != 32) begin bad++; $display("FAIL umul_busy_cycles: got %0d want 32", nb); end
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL umul_busy_in_done: got %b want 0", bus.Busy); end
        total++; if (bus.Result2 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL umul_r2: got %h want fffffffe", bus.Result2); end
        total++; if (bus.Result1 !== 32'h0000_0001) begin bad++; $display("FAIL umul_r1: got %h want 00000001", bus.Result1); end
        tick();
        total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL umul_done_pulse: got %b want 0", bus.Done); end
        total++; if (bus.Result1 !== 32'h0000_0001) begin bad++; $display("FAIL umul_r1_hold: got %h want 00000001", bus.Result1); end
    endtask

    task automatic test_signed();
        int idx, nb;
        start_op(2'b00, -32'sd3, 32'd7, 4'd2);
        wait_done(idx, nb);
        total++; if (bus.Result1 !== 32'hFFFF_FFEB) begin bad++; $display("FAIL smul_r1: got %h want ffffffeb", bus.Result1); end
        total++; if (bus.Result2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL smul_r2: got %h want ffffffff", bus.Result2); end
        tick();
        start_op(2'b10, -32'sd7, 32'd2, 4'd3);
        wait_done(idx, nb);
        total++; if (idx != 33) begin bad++; $display("FAIL sdiv_done_cycle: got %0d want 33", idx); end
        total++; if (bus.Result1 !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sdiv_r1: got %h want fffffffd", bus.Result1); end
        total++; if (bus.Result2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdiv_r2: got %h want ffffffff", bus.Result2); end
        tick();
    endtask

    task automatic test_div_corner();
        int idx, nb;
        start_op(2'b11, 32'd100, 32'd0, 4'd4);
        wait_done(idx, nb);
        total++; if (idx != 33) begin bad++; $display("FAIL div0_done_cycle: got %0d want 33", idx); end
        total++; if (bus.Result1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_r1: got %h want ffffffff", bus.Result1); end
        total++; if (bus.Result2 !== 32'h0000_0064) begin bad++; $display("FAIL div0_r2: got %h want 00000064", bus.Result2); end
        tick();
        start_op(2'b10, 32'hFFFF_FFFB, 32'd0, 4'd4);
        wait_done(idx, nb);
        total++; if (bus.Result1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdiv0_r1: got %h want ffffffff", bus.Result1); end
        total++; if (bus.Result2 !== 32'hFFFF_FFFB) begin bad++; $display("FAIL sdiv0_r2: got %h want fffffffb", bus.Result2); end
        tick();
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4);
        wait_done(idx, nb);
        total++; if (bus.Result1 !== 32'h8000_0000) begin bad++; $display("FAIL sovf_r1: got %h want 80000000", bus.Result1); end
        total++; if (bus.Result2 !== 32'h0) begin bad++; $display("FAIL sovf_r2: got %h want 0", bus.Result2); end
        tick();
    endtask

    task automatic test_back_to_back();
        int idx, nb;
        start_op(2'b11, 32'd1000, 32'd10, 4'd5);
        for (int i = 1; i < 10; i++) tick();
        bus.MCycleOp = 2'b01; bus.Operand1 = 32'd77; bus.Operand2 = 32'd3; bus.WA3E = 4'd9;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        total++; if (bus.WA3R !== 4'd5) begin bad++; $display("FAIL b2b_wa3r_ignored: got %0d want 5", bus.WA3R); end
        total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_ignored: got %b want 1", bus.Busy); end
        idx = 11;
        while (bus.Done !== 1'b1 && idx < 200) begin tick(); idx++; end
        total++; if (idx != 33) begin bad++; $display("FAIL b2b_first_done: got %0d want 33", idx); end
        total++; if (bus.Result1 !== 32'd100) begin bad++; $display("FAIL b2b_first_r1: got %0d want 100", bus.Result1); end
        total++; if (bus.Result2 !== 32'd0) begin bad++; $display("FAIL b2b_first_r2: got %0d want 0", bus.Result2); end
        start_op(2'b11, 32'd50, 32'd7, 4'd9);
        total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy: got %b want 1", bus.Busy); end
        total++; if (bus.WA3R !== 4'd9) begin bad++; $display("FAIL b2b_second_wa3r: got %0d want 9", bus.WA3R); end
        total++; if (bus.Result1 !== 32'd100) begin bad++; $display("FAIL b2b_r1_hold: got %0d want 100", bus.Result1); end
        wait_done(idx, nb);
        total++; if (idx != 33) begin bad++; $display("FAIL b2b_second_done: got %0d want 33", idx); end
        total++; if (bus.Result1 !== 32'd7) begin bad++; $display("FAIL b2b_second_r1: got %0d want 7", bus.Result1); end
        total++; if (bus.Result2 !== 32'd1) begin bad++; $display("FAIL b2b_second_r2: got %0d want 1", bus.Result2); end
        tick();
    endtask

    task automatic test_reset_mid();
        int idx, nb, ndone;
        start_op(2'b10, -32'sd7, 32'd2, 4'd3);
        for (int i = 1; i < 12; i++) tick();
        rst_n = 1'b0;
        #1;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", bus.Busy); end
        total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", bus.Done); end
        total++; if (bus.Result1 !== 32'h0) begin bad++; $display("FAIL rmid_r1: got %h want 0", bus.Result1); end
        total++; if (bus.Result2 !== 32'h0) begin bad++; $display("FAIL rmid_r2: got %h want 0", bus.Result2); end
        total++; if (bus.WA3R !== 4'h0) begin bad++; $display("FAIL rmid_wa3r: got %h want 0", bus.WA3R); end
        tick(); tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL rmid_no_done: got %0d active cycles want 0", ndone); end
        start_op(2'b11, 32'd20, 32'd6, 4'd4);
        wait_done(idx, nb);
        total++; if (idx != 33) begin bad++; $display("FAIL rmid_after_done: got %0d want 33", idx); end
        total++; if (bus.Result1 !== 32'd3) begin bad++; $display("FAIL rmid_after_r1: got %0d want 3", bus.Result1); end
        total++; if (bus.Result2 !== 32'd2) begin bad++; $display("FAIL rmid_after_r2: got %0d want 2", bus.Result2); end
        total++; if (bus.WA3R !== 4'd4) begin bad++; $display("FAIL rmid_after_wa3r: got %0d want 4", bus.WA3R); end
        tick();
    endtask

    task automatic test_early_term();
        int idx, nb;
        start_op(2'b01, 32'd5, 32'd3, 4'd6);
        wait_done(idx, nb);
`ifdef MCYCLE_EARLY_TERM_EN
        total++; if (idx != 3) begin bad++; $display("FAIL et_5x3_done: got %0d want 3", idx); end
`else
        total++; if (idx != 33) begin bad++; $display("FAIL et_5x3_done: got %0d want 33", idx); end
`endif
        total++; if (bus.Result1 !== 32'd15) begin bad++; $display("FAIL et_5x3_r1: got %0d want 15", bus.Result1); end
        total++; if (bus.Result2 !== 32'd0) begin bad++; $display("FAIL et_5x3_r2: got %0d want 0", bus.Result2); end
        tick();
        start_op(2'b01, 32'd7, 32'd0, 4'd6);
        wait_done(idx, nb);
`ifdef MCYCLE_EARLY_TERM_EN
        total++; if (idx != 2) begin bad++; $display("FAIL et_7x0_done: got %0d want 2", idx); end
`else
        total++; if (idx != 33) begin bad++; $display("FAIL et_7x0_done: got %0d want 33", idx); end
`endif
        total++; if (bus.Result1 !== 32'd0) begin bad++; $display("FAIL et_7x0_r1: got %0d want 0", bus.Result1); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_umul();
        test_signed();
        test_div_corner();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
